pe_ctrl: RTL and testbench

Sequencer for a single PE. It accepts an input-activation (iact) stream over a valid/ready handshake and writes it into the PE's iact FIFO. It then drives the PE's enable and weight-ROM address through one compute pass, accumulates the PE's wxi products into per-iact partial sums, and reports completion. It sits between the iact buffer/NoC and one PE, and is replicated per PE in the array.

---
 rtl/pe_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pe_ctrl.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ctrl.sv
// pe_ctrl: per-PE sequencer. Loads an iact stream into the PE FIFO, runs one
// compute pass over len*NUM_OF_CHANNEL weights, accumulates the PE products
// into one partial sum per iact and pulses done at the end of the pass.
// Optional build macro: PE_CTRL_ACC_SAT_EN (saturating accumulator; when
// undefined the accumulator wraps modulo 2^ACC_BITWIDTH).
module pe_ctrl #(
   parameter int DATA_BITWIDTH      = 8,
   parameter int NUM_OF_CHANNEL     = 1,
   parameter int ROM_ADDR_BITWIDTH  = 4,
   parameter int FIFO_ADDR_BITWIDTH = 4,
   parameter int PE_LAT             = 1,
   parameter int ACC_BITWIDTH       = 24
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          start,
   input  logic [FIFO_ADDR_BITWIDTH:0]   len,
   input  logic                          iact_valid,
   input  logic [DATA_BITWIDTH-1:0]      iact_data,
   output logic                          iact_ready,
   output logic                          pe_we,
   output logic [DATA_BITWIDTH-1:0]      pe_din,
   output logic                          pe_en,
   output logic [ROM_ADDR_BITWIDTH-1:0]  rom_addr,
   input  logic [2*DATA_BITWIDTH-1:0]    wxi,
   output logic [ACC_BITWIDTH-1:0]       psum,
   output logic                          psum_valid,
   output logic                          busy,
   output logic                          done
);

   localparam int LEN_W = FIFO_ADDR_BITWIDTH + 1;
   localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << FIFO_ADDR_BITWIDTH);
   localparam logic [ROM_ADDR_BITWIDTH-1:0] LAST_ADDR = ROM_ADDR_BITWIDTH'(NUM_OF_CHANNEL - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_FLUSH, S_DONE} state_t;

   state_t                         state_reg;
   logic [LEN_W-1:0]               len_reg;
   logic [LEN_W-1:0]               load_cnt_reg;
   logic [LEN_W-1:0]               iact_cnt_reg;
   logic [2:0]                     flush_cnt_reg;
   logic                           iact_ready_reg;
   logic                           pe_we_reg;
   logic [DATA_BITWIDTH-1:0]       pe_din_reg;
   logic                           pe_en_reg;
   logic [ROM_ADDR_BITWIDTH-1:0]   rom_addr_reg;
   logic                           busy_reg;
   logic                           done_reg;
   logic [PE_LAT-1:0]              vld_dly_reg;
   logic [PE_LAT-1:0]              first_dly_reg;
   logic [PE_LAT-1:0]              last_dly_reg;
   logic [ACC_BITWIDTH-1:0]        acc_reg;
   logic [ACC_BITWIDTH-1:0]        psum_reg;
   logic                           psum_valid_reg;

   logic                           len_ok;
   logic [ACC_BITWIDTH-1:0]        wxi_ext;
   logic [ACC_BITWIDTH-1:0]        acc_add;
   logic [ACC_BITWIDTH-1:0]        acc_next;

   assign len_ok  = (len != '0) && (len <= DEPTH);
   assign wxi_ext = ACC_BITWIDTH'(wxi);

   // Accumulator datapath: first product loads, later products add
`ifdef PE_CTRL_ACC_SAT_EN
   logic [ACC_BITWIDTH:0] acc_sum;
   assign acc_sum = {1'b0, acc_reg} + {1'b0, wxi_ext};
   assign acc_add = acc_sum[ACC_BITWIDTH] ? {ACC_BITWIDTH{1'b1}} : acc_sum[ACC_BITWIDTH-1:0];
`else
   assign acc_add = acc_reg + wxi_ext;
`endif
   assign acc_next = first_dly_reg[PE_LAT-1] ? wxi_ext : acc_add;

   // Pass sequencer: load handshake, compute stepping, flush wait and done pulse
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_reg      <= S_IDLE;
         len_reg        <= '0;
         load_cnt_reg   <= '0;
         iact_cnt_reg   <= '0;
         flush_cnt_reg  <= '0;
         iact_ready_reg <= 1'b0;
         pe_we_reg      <= 1'b0;
         pe_din_reg     <= '0;
         pe_en_reg      <= 1'b0;
         rom_addr_reg   <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         pe_we_reg <= 1'b0;
         done_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start && len_ok) begin
                  len_reg        <= len;
                  load_cnt_reg   <= '0;
                  iact_ready_reg <= 1'b1;
                  busy_reg       <= 1'b1;
                  state_reg      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (iact_valid && iact_ready_reg) begin
                  pe_we_reg    <= 1'b1;
                  pe_din_reg   <= iact_data;
                  load_cnt_reg <= load_cnt_reg + LEN_W'(1);
                  if (load_cnt_reg == len_reg - LEN_W'(1)) begin
                     iact_ready_reg <= 1'b0;
                     pe_en_reg      <= 1'b1;
                     rom_addr_reg   <= '0;
                     iact_cnt_reg   <= '0;
                     state_reg      <= S_COMPUTE;
                  end
               end
            end
            S_COMPUTE: begin
               if (rom_addr_reg == LAST_ADDR) begin
                  rom_addr_reg <= '0;
                  if (iact_cnt_reg == len_reg - LEN_W'(1)) begin
                     pe_en_reg     <= 1'b0;
                     flush_cnt_reg <= '0;
                     state_reg     <= S_FLUSH;
                  end else begin
                     iact_cnt_reg <= iact_cnt_reg + LEN_W'(1);
                  end
               end else begin
                  rom_addr_reg <= rom_addr_reg + ROM_ADDR_BITWIDTH'(1);
               end
            end
            S_FLUSH: begin
               // The last product is accumulated PE_LAT cycles after the final
               // pe_en; done follows the cycle after its psum_valid.
               if (flush_cnt_reg == 3'(PE_LAT)) begin
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  flush_cnt_reg <= flush_cnt_reg + 3'd1;
               end
            end
            S_DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // First/last flag delay line aligning each pe_en cycle with its wxi
   always_ff @(posedge clk) begin
      if (!rstN) begin
         vld_dly_reg   <= '0;
         first_dly_reg <= '0;
         last_dly_reg  <= '0;
      end else begin
         vld_dly_reg[0]   <= pe_en_reg;
         first_dly_reg[0] <= pe_en_reg && (rom_addr_reg == '0);
         last_dly_reg[0]  <= pe_en_reg && (rom_addr_reg == LAST_ADDR);
         for (int i = PE_LAT - 1; i > 0; i--) begin
            vld_dly_reg[i]   <= vld_dly_reg[i-1];
            first_dly_reg[i] <= first_dly_reg[i-1];
            last_dly_reg[i]  <= last_dly_reg[i-1];
         end
      end
   end

   // Partial-sum accumulator and psum presentation on the last product
   always_ff @(posedge clk) begin
      if (!rstN) begin
         acc_reg        <= '0;
         psum_reg       <= '0;
         psum_valid_reg <= 1'b0;
      end else begin
         psum_valid_reg <= 1'b0;
         if (vld_dly_reg[PE_LAT-1]) begin
            acc_reg <= acc_next;
            if (last_dly_reg[PE_LAT-1]) begin
               psum_reg       <= acc_next;
               psum_valid_reg <= 1'b1;
            end
         end
      end
   end

   assign iact_ready = iact_ready_reg;
   assign pe_we      = pe_we_reg;
   assign pe_din     = pe_din_reg;
   assign pe_en      = pe_en_reg;
   assign rom_addr   = rom_addr_reg;
   assign psum       = psum_reg;
   assign psum_valid = psum_valid_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_pe_ctrl.sv
// Testbench for pe_ctrl: three instances (NUM_OF_CHANNEL 1, 3, and 2 with a
// 16-bit accumulator) share the stimulus; each has its own PE product model
// and psum scoreboard queue.
module tb_pe_ctrl;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  len = '0;
   logic        iact_valid = 1'b0;
   logic [7:0]  iact_data = '0;

   logic        rdy1, we1, en1, pv1, busy1, done1;
   logic [7:0]  din1;
   logic [3:0]  ra1;
   logic [15:0] wxi1;
   logic [23:0] psum1;

   logic        rdy3, we3, en3, pv3, busy3, done3;
   logic [7:0]  din3;
   logic [3:0]  ra3;
   logic [15:0] wxi3;
   logic [23:0] psum3;

   logic        rdy2, we2, en2, pv2, busy2, done2;
   logic [7:0]  din2;
   logic [3:0]  ra2;
   logic [15:0] wxi2;
   logic [15:0] psum2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int tab1[64];
   int tab3[64];
   int tab2[64];
   int k1 = 0, k3 = 0, k2 = 0;

   longint     q1[$];
   longint     q3[$];
   longint     q2[$];
   logic [7:0] qdin[$];
   longint     obs3[$];
   longint     last2 = 0;
   longint     exp_ps;
   logic [7:0] exp_din;

   int we_cnt = 0, en1_cnt = 0, en3_cnt = 0, en2_cnt = 0;
   int done1_cnt = 0, done3_cnt = 0, done2_cnt = 0;
   int done1_cyc = 0, done3_cyc = 0, done2_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pe_ctrl #(.NUM_OF_CHANNEL(1)) dut1 (
      .clk(clk), .rstN(rstN), .start(start), .len(len),
      .iact_valid(iact_valid), .iact_data(iact_data), .iact_ready(rdy1),
      .pe_we(we1), .pe_din(din1), .pe_en(en1), .rom_addr(ra1), .wxi(wxi1),
      .psum(psum1), .psum_valid(pv1), .busy(busy1), .done(done1));

   pe_ctrl #(.NUM_OF_CHANNEL(3)) dut3 (
      .clk(clk), .rstN(rstN), .start(start), .len(len),
      .iact_valid(iact_valid), .iact_data(iact_data), .iact_ready(rdy3),
      .pe_we(we3), .pe_din(din3), .pe_en(en3), .rom_addr(ra3), .wxi(wxi3),
      .psum(psum3), .psum_valid(pv3), .busy(busy3), .done(done3));

   pe_ctrl #(.NUM_OF_CHANNEL(2), .ACC_BITWIDTH(16)) dut2 (
      .clk(clk), .rstN(rstN), .start(start), .len(len),
      .iact_valid(iact_valid), .iact_data(iact_data), .iact_ready(rdy2),
      .pe_we(we2), .pe_din(din2), .pe_en(en2), .rom_addr(ra2), .wxi(wxi2),
      .psum(psum2), .psum_valid(pv2), .busy(busy2), .done(done2));

   // PE models: k-th pe_en of a pass returns table entry k one cycle later
   always @(posedge clk) begin
      if (!rstN) begin
         wxi1 <= '0; wxi3 <= '0; wxi2 <= '0;
         k1 <= 0; k3 <= 0; k2 <= 0;
      end else begin
         if (start && !busy1) k1 <= 0;
         else if (en1) begin wxi1 <= 16'(tab1[k1 & 63]); k1 <= k1 + 1; end
         if (start && !busy3) k3 <= 0;
         else if (en3) begin wxi3 <= 16'(tab3[k3 & 63]); k3 <= k3 + 1; end
         if (start && !busy2) k2 <= 0;
         else if (en2) begin wxi2 <= 16'(tab2[k2 & 63]); k2 <= k2 + 1; end
      end
   end

   // Output monitor / scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (rstN) begin
         if (we1) begin
            we_cnt++;
            checks++;
            if (qdin.size() == 0) begin
               failures++;
               $display("FAIL pe_din_unexpected got=%0d want=none cyc=%0d", din1, cyc);
            end else begin
               exp_din = qdin.pop_front();
               if (din1 !== exp_din) begin
                  failures++;
                  $display("FAIL pe_din got=%0d want=%0d cyc=%0d", din1, exp_din, cyc);
               end
            end
         end
         if (en1) en1_cnt++;
         if (en2) en2_cnt++;
         if (en3) begin
            checks++;
            if (ra3 !== 4'(en3_cnt % 3)) begin
               failures++;
               $display("FAIL rom_addr3 got=%0d want=%0d cyc=%0d", ra3, en3_cnt % 3, cyc);
            end
            en3_cnt++;
         end
         if (pv1) begin
            checks++;
            if (q1.size() == 0) begin
               failures++;
               $display("FAIL psum1_unexpected got=%0d want=none", psum1);
            end else begin
               exp_ps = q1.pop_front();
               if (psum1 !== 24'(exp_ps)) begin
                  failures++;
                  $display("FAIL psum1 got=%0d want=%0d cyc=%0d", psum1, exp_ps, cyc);
               end
            end
         end
         if (pv3) begin
            obs3.push_back(longint'(psum3));
            checks++;
            if (q3.size() == 0) begin
               failures++;
               $display("FAIL psum3_unexpected got=%0d want=none", psum3);
            end else begin
               exp_ps = q3.pop_front();
               if (psum3 !== 24'(exp_ps)) begin
                  failures++;
                  $display("FAIL psum3 got=%0d want=%0d cyc=%0d", psum3, exp_ps, cyc);
               end
            end
         end
         if (pv2) begin
            last2 = longint'(psum2);
            checks++;
            if (q2.size() == 0) begin
               failures++;
               $display("FAIL psum2_unexpected got=%0d want=none", psum2);
            end else begin
               exp_ps = q2.pop_front();
               if (psum2 !== 16'(exp_ps)) begin
                  failures++;
                  $display("FAIL psum2 got=%0d want=%0d cyc=%0d", psum2, exp_ps, cyc);
               end
            end
         end
         if (done1) begin done1_cnt++; done1_cyc = cyc; end
         if (done3) begin done3_cnt++; done3_cyc = cyc; end
         if (done2) begin done2_cnt++; done2_cyc = cyc; end
      end
   end

   // Expected psums for the first l iacts of the current tables
   task automatic push_expect(input int l);
      longint s;
      for (int i = 0; i < l; i++) begin
         q1.push_back(longint'(tab1[i]) & 64'hFFFF);
         s = 0;
         for (int j = 0; j < 3; j++) s += longint'(tab3[3*i+j]) & 64'hFFFF;
         q3.push_back(s & 64'hFFFFFF);
         s = (longint'(tab2[2*i]) & 64'hFFFF) + (longint'(tab2[2*i+1]) & 64'hFFFF);
`ifdef PE_CTRL_ACC_SAT_EN
         if (s > 64'hFFFF) s = 64'hFFFF;
`else
         s = s & 64'hFFFF;
`endif
         q2.push_back(s);
      end
   endtask

   task automatic fill_tables(input int seed);
      for (int i = 0; i < 64; i++) begin
         tab1[i] = (i * 37 + seed) & 16'hFFFF;
         tab3[i] = (i * 5 + seed) & 16'hFF;
         tab2[i] = (i * 3 + seed) & 16'hFF;
      end
   endtask

   // Start a pass and stream l iacts; returns start cycle and last-beat cycle
   task automatic run_pass(input int l, input bit toggle, input int base,
                           output int t0, output int tlast);
      int  beats;
      bit  hs;
      beats = 0; tlast = 0;
      we_cnt = 0; en1_cnt = 0; en2_cnt = 0; en3_cnt = 0;
      push_expect(l);
      iact_data = 8'(base);
      @(posedge clk); #1;
      start = 1'b1; len = 5'(l); t0 = cyc;
      for (int c = 0; c <= 200; c++) begin
         iact_valid = toggle ? ((c % 2) == 0) : 1'b1;
         @(negedge clk);
         hs = iact_valid && rdy1;
         if (hs) begin qdin.push_back(iact_data); beats++; tlast = cyc; end
         @(posedge clk); #1;
         start = 1'b0;
         if (hs) iact_data = iact_data + 8'd1;
         if (beats == l) break;
      end
      iact_valid = 1'b0;
      checks++;
      if (beats !== l) begin
         failures++;
         $display("FAIL load_beats got=%0d want=%0d", beats, l);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while ((busy1 || busy2 || busy3) && n < 400);
      checks++;
      if (busy1 || busy2 || busy3) begin
         failures++;
         $display("FAIL idle_timeout got=busy want=idle");
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (q1.size() + q3.size() + q2.size() + qdin.size() != 0) begin
         failures++;
         $display("FAIL %s_drained got=%0d/%0d/%0d/%0d want=0", name, q1.size(), q3.size(), q2.size(), qdin.size());
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rdy1, we1, din1, en1, ra1, psum1, pv1, busy1, done1} !== 42'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", {rdy1, we1, din1, en1, ra1, psum1, pv1, busy1, done1});
      end
      checks++;
      if ({busy3, busy2, rdy3, rdy2, psum2, psum3} !== '0) begin
         failures++;
         $display("FAIL reset_others got=%b%b want=00", busy3, busy2);
      end
      @(posedge clk); #1;
      rstN = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_stream();
      int t0, tl, d1;
      fill_tables(7);
      d1 = done1_cnt;
      run_pass(4, 1'b0, 1, t0, tl);
      @(negedge clk);
      checks++;
      if (en1 !== 1'b1 || rdy1 !== 1'b0) begin
         failures++;
         $display("FAIL stream_first_en got=en%b rdy%b want=en1 rdy0", en1, rdy1);
      end
      wait_idle();
      checks++;
      if (we_cnt !== 4 || en1_cnt !== 4) begin
         failures++;
         $display("FAIL stream_counts got=we%0d en%0d want=we4 en4", we_cnt, en1_cnt);
      end
      checks++;
      if (done1_cyc !== t0 + 11 || done1_cnt !== d1 + 1) begin
         failures++;
         $display("FAIL stream_done1 got=%0d want=%0d", done1_cyc - t0, 11);
      end
      checks++;
      if (done3_cyc !== t0 + 19 || done2_cyc !== t0 + 15) begin
         failures++;
         $display("FAIL stream_done32 got=%0d,%0d want=19,15", done3_cyc - t0, done2_cyc - t0);
      end
      checks++;
      if (en3_cnt !== 12 || en2_cnt !== 8) begin
         failures++;
         $display("FAIL stream_en32 got=%0d,%0d want=12,8", en3_cnt, en2_cnt);
      end
      check_drained("stream");
      $display("test_stream t0=%0d done1=+%0d", t0, done1_cyc - t0);
   endtask

   task automatic test_channels();
      int t0, tl;
      fill_tables(3);
      tab3[0] = 10; tab3[1] = 20; tab3[2] = 30; tab3[3] = 1; tab3[4] = 2; tab3[5] = 3;
      obs3.delete();
      run_pass(2, 1'b0, 40, t0, tl);
      wait_idle();
      checks++;
      if (obs3.size() !== 2) begin
         failures++;
         $display("FAIL channels_count got=%0d want=2", obs3.size());
      end else begin
         checks++;
         if (obs3[0] !== 60 || obs3[1] !== 6) begin
            failures++;
            $display("FAIL channels_psum got=%0d,%0d want=60,6", obs3[0], obs3[1]);
         end
      end
      checks++;
      if (en3_cnt !== 6) begin
         failures++;
         $display("FAIL channels_en got=%0d want=6", en3_cnt);
      end
      check_drained("channels");
      $display("test_channels psums=%0d", obs3.size());
   endtask

   task automatic test_bubbles();
      int t0, tl, d1;
      fill_tables(11);
      d1 = done1_cnt;
      run_pass(2, 1'b1, 90, t0, tl);
      start = 1'b1; len = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      checks++;
      if (we_cnt !== 2 || en1_cnt !== 2) begin
         failures++;
         $display("FAIL bubbles_counts got=we%0d en%0d want=we2 en2", we_cnt, en1_cnt);
      end
      checks++;
      if (done1_cyc !== t0 + 9 || done1_cnt !== d1 + 1) begin
         failures++;
         $display("FAIL bubbles_done got=%0d want=9", done1_cyc - t0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || done1_cnt !== d1 + 1) begin
         failures++;
         $display("FAIL busy_start_ignored got=busy%b want=busy0", busy1);
      end
      check_drained("bubbles");
      $display("test_bubbles done1=+%0d", done1_cyc - t0);
   endtask

   task automatic test_illegal_len();
      int lv[2];
      lv[0] = 0; lv[1] = 17;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         start = 1'b1; len = 5'(lv[i]);
         @(posedge clk); #1;
         start = 1'b0;
         repeat (3) @(negedge clk);
         checks++;
         if (busy1 !== 1'b0 || rdy1 !== 1'b0 || busy3 !== 1'b0) begin
            failures++;
            $display("FAIL illegal_len%0d got=busy%b want=busy0", lv[i], busy1);
         end
         $display("test_illegal_len len=%0d", lv[i]);
      end
   endtask

   task automatic test_full();
      int t0, tl;
      fill_tables(21);
      run_pass(16, 1'b0, 200, t0, tl);
      @(negedge clk);
      checks++;
      if (rdy1 !== 1'b0 || en1 !== 1'b1) begin
         failures++;
         $display("FAIL full_ready_fall got=rdy%b en%b want=rdy0 en1", rdy1, en1);
      end
      wait_idle();
      checks++;
      if (we_cnt !== 16 || tl !== t0 + 16 || en1_cnt !== 16) begin
         failures++;
         $display("FAIL full_counts got=we%0d last=+%0d want=we16 last=+16", we_cnt, tl - t0);
      end
      check_drained("full");
      $display("test_full we=%0d", we_cnt);
   endtask

   task automatic test_reset_midpass();
      int t0, tl, d1, d3, d2;
      fill_tables(5);
      run_pass(4, 1'b0, 60, t0, tl);
      @(posedge clk); #1;
      rstN = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      checks++;
      if ({rdy1, we1, din1, en1, ra1, psum1, pv1, busy1, done1} !== 42'd0 || busy3 !== 1'b0 || busy2 !== 1'b0) begin
         failures++;
         $display("FAIL midpass_reset got=%h want=0", {rdy1, we1, din1, en1, ra1, psum1, pv1, busy1, done1});
      end
      q1.delete(); q3.delete(); q2.delete(); qdin.delete();
      d1 = done1_cnt; d3 = done3_cnt; d2 = done2_cnt;
      repeat (30) @(negedge clk);
      checks++;
      if (done1_cnt !== d1 || done3_cnt !== d3 || done2_cnt !== d2 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL midpass_no_done got=%0d want=%0d", done1_cnt, d1);
      end
      run_pass(3, 1'b0, 70, t0, tl);
      wait_idle();
      checks++;
      if (done1_cyc !== t0 + 9 || done1_cnt !== d1 + 1) begin
         failures++;
         $display("FAIL midpass_restart_done got=%0d want=9", done1_cyc - t0);
      end
      check_drained("restart");
      $display("test_reset_midpass restart done1=+%0d", done1_cyc - t0);
   endtask

   task automatic test_saturation();
      int t0, tl;
      longint want;
      fill_tables(1);
      tab2[0] = 16'hFFFF; tab2[1] = 16'hFFFF;
`ifdef PE_CTRL_ACC_SAT_EN
      want = 64'hFFFF;
`else
      want = 64'hFFFE;
`endif
      last2 = 0;
      run_pass(1, 1'b0, 9, t0, tl);
      wait_idle();
      checks++;
      if (last2 !== want) begin
         failures++;
         $display("FAIL saturation got=%h want=%h", last2, want);
      end
      check_drained("saturation");
      $display("test_saturation psum2=%h", last2);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin tab1[i] = 0; tab3[i] = 0; tab2[i] = 0; end
      test_reset();
      test_stream();
      test_channels();
      test_bubbles();
      test_illegal_len();
      test_full();
      test_reset_midpass();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
